// File: rtl/sign_window_rows_if.sv
// Stream bundle for sign_window_rows.
//   master : upstream side, drives i_* and observes o_*
//   slave  : window generator, consumes i_* and drives o_*
//   i_vsync/i_valid/i_tdata : frame start, element strobe, signed element
//   o_vsync/o_hsync/o_valid/o_last/o_busy/o_err/o_tdata : window stream and status
interface sign_window_rows_if #(
  parameter int unsigned WIDTH_D = 27,
  parameter int unsigned LEN     = 3
);
  logic               i_vsync;
  logic               i_valid;
  logic [WIDTH_D-1:0] i_tdata;
  logic               o_vsync;
  logic               o_hsync;
  logic               o_valid;
  logic               o_last;
  logic               o_busy;
  logic               o_err;
  logic [2*LEN-1:0]   o_tdata;

  modport master (
    output i_vsync, i_valid, i_tdata,
    input  o_vsync, o_hsync, o_valid, o_last, o_busy, o_err, o_tdata
  );

  modport slave (
    input  i_vsync, i_valid, i_tdata,
    output o_vsync, o_hsync, o_valid, o_last, o_busy, o_err, o_tdata
  );
endinterface

// File: rtl/sign_window_rows.sv
// Binarised row-window generator: sign-quantises a raster stream (channel,
// column, row order) and emits LEN vertically adjacent rows per element as
// 2-bit codes, newest row in the MSB slot. Top/bottom padding is masked in,
// and the tail rows are flushed internally so SIZE rows leave per frame.
//   i_sclk : clock
//   i_rst  : synchronous active-high reset
//   bus    : slave side of sign_window_rows_if (input stream, window output)
module sign_window_rows #(
  parameter int unsigned WIDTH_D = 27,
  parameter int unsigned SIZE    = 28,
  parameter int unsigned CHANNEL = 128,
  parameter int unsigned LEN     = 3
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  sign_window_rows_if.slave bus
);

  localparam int unsigned ROWW   = SIZE * CHANNEL;
  localparam int unsigned HALF   = (LEN - 1) / 2;
  localparam int unsigned NBUF   = LEN - 1;
  localparam int unsigned ROWS   = SIZE + HALF;
  localparam int unsigned ADDR_W = (ROWW > 1) ? $clog2(ROWW) : 1;
  localparam int unsigned ROW_W  = $clog2(ROWS + 1);
  localparam int unsigned DW     = 2 * LEN;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic              flush_c, strobe_c, err_set_c, end_row_c, last_c, emit_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic [ROW_W-1:0]  cur_row_c;
  logic [1:0]        code_c;
  logic [LEN-1:0]    keep_c;
  logic [DW-1:0]     tdata_c;

  // Stage 1: registered RAM read plus sideband of the element being windowed.
  logic              s1_valid_q, s1_hs_q, s1_vs_q, s1_last_q;
  logic [1:0]        s1_code_q;
  logic [LEN-1:0]    s1_keep_q;
  logic [1:0]        rd_q [NBUF];
  logic [1:0]        mem_q [NBUF][ROWW];

  // Stage 2: output registers.
  logic              o_vsync_q, o_hsync_q, o_valid_q, o_last_q, o_busy_q, o_err_q;
  logic [DW-1:0]     o_tdata_q;

  // Strobe, counter advance, padding mask and window assembly.
  always_comb begin
    flush_c    = (state_q == FLUSH) && !bus.i_vsync;
    strobe_c   = flush_c || (bus.i_valid && (bus.i_vsync || (state_q != FLUSH)));
    err_set_c  = bus.i_valid && (state_q == FLUSH) && !bus.i_vsync;
    // A vsync-coincident element is element 0 of the new frame.
    cur_addr_c = bus.i_vsync ? '0 : addr_q;
    cur_row_c  = bus.i_vsync ? '0 : row_q;
    end_row_c  = (cur_addr_c == ADDR_W'(ROWW - 1));
    last_c     = end_row_c && (cur_row_c == ROW_W'(ROWS - 1));
    emit_c     = strobe_c && (cur_row_c >= ROW_W'(HALF));

    code_c = 2'b00;
    if (!flush_c && (bus.i_tdata != '0)) begin
      code_c = bus.i_tdata[WIDTH_D-1] ? 2'b11 : 2'b01;
    end

    // Slot j carries source row cur_row-(LEN-1)+j; keep it only inside 0..SIZE-1.
    keep_c = '0;
    for (int unsigned j = 0; j < LEN; j++) begin
      keep_c[j] = ((32'(cur_row_c) + j) >= (LEN - 1)) &&
                  ((32'(cur_row_c) + j) <  (SIZE + LEN - 1));
    end

    addr_d  = addr_q;
    row_d   = row_q;
    state_d = state_q;
    if (strobe_c) begin
      addr_d = end_row_c ? '0 : cur_addr_c + ADDR_W'(1);
      row_d  = last_c ? '0 : (end_row_c ? cur_row_c + ROW_W'(1) : cur_row_c);
      if (last_c)                        state_d = IDLE;
      else if (row_d >= ROW_W'(SIZE))    state_d = FLUSH;
      else if (row_d >= ROW_W'(HALF))    state_d = RUN;
      else                               state_d = FILL;
    end else if (bus.i_vsync) begin
      addr_d  = '0;
      row_d   = '0;
      state_d = IDLE;
    end

    // Buffer b delays by b+1 rows, so it lands in slot LEN-2-b.
    tdata_c = '0;
    tdata_c[2*(LEN-1) +: 2] = s1_keep_q[LEN-1] ? s1_code_q : 2'b00;
    for (int unsigned j = 0; j < NBUF; j++) begin
      tdata_c[2*j +: 2] = s1_keep_q[j] ? rd_q[NBUF-1-j] : 2'b00;
    end
  end

  // Chained row buffers: read-before-write at a shared address shifts each row down one buffer.
  always_ff @(posedge i_sclk) begin
    if (!i_rst && strobe_c) begin
      mem_q[0][cur_addr_c] <= code_c;
      for (int unsigned b = 1; b < NBUF; b++) begin
        mem_q[b][cur_addr_c] <= mem_q[b-1][cur_addr_c];
      end
      for (int unsigned b = 0; b < NBUF; b++) begin
        rd_q[b] <= mem_q[b][cur_addr_c];
      end
    end
  end

  // FSM, counters, pipeline and output registers.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_code_q  <= 2'b00;
      s1_keep_q  <= '0;
      o_vsync_q  <= 1'b0;
      o_hsync_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_busy_q   <= 1'b0;
      o_err_q    <= 1'b0;
      o_tdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      if (err_set_c) o_err_q <= 1'b1;
      s1_valid_q <= emit_c;
      s1_hs_q    <= (cur_addr_c == '0);
      s1_vs_q    <= (cur_addr_c == '0) && (cur_row_c == ROW_W'(HALF));
      s1_last_q  <= last_c;
      s1_code_q  <= code_c;
      s1_keep_q  <= keep_c;
      o_busy_q   <= (state_d == FLUSH);
      // vsync squashes whatever was in flight from the aborted frame.
      o_valid_q  <= s1_valid_q && !bus.i_vsync;
      o_hsync_q  <= s1_valid_q && !bus.i_vsync && s1_hs_q;
      o_vsync_q  <= s1_valid_q && !bus.i_vsync && s1_vs_q;
      o_last_q   <= s1_valid_q && !bus.i_vsync && s1_last_q;
      o_tdata_q  <= (s1_valid_q && !bus.i_vsync) ? tdata_c : '0;
    end
  end

  assign bus.o_vsync = o_vsync_q;
  assign bus.o_hsync = o_hsync_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_busy  = o_busy_q;
  assign bus.o_err   = o_err_q;
  assign bus.o_tdata = o_tdata_q;

endmodule

// File: tb/tb_sign_window_rows.sv
module tb_sign_window_rows;
  localparam int WD = 27;
  localparam int SZ = 4;
  localparam int CH = 2;
  localparam int RW = SZ * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          valid = 1'b0;
  logic [WD-1:0] tdata = '0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sign_window_rows_if #(.WIDTH_D(WD), .LEN(3)) bus3 ();
  sign_window_rows_if #(.WIDTH_D(WD), .LEN(5)) bus5 ();

  assign bus3.i_vsync = vsync;
  assign bus3.i_valid = valid;
  assign bus3.i_tdata = tdata;
  assign bus5.i_vsync = vsync;
  assign bus5.i_valid = valid;
  assign bus5.i_tdata = tdata;

  sign_window_rows #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(3)) dut3 (
    .i_sclk(clk), .i_rst(rst), .bus(bus3));
  sign_window_rows #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(5)) dut5 (
    .i_sclk(clk), .i_rst(rst), .bus(bus5));

  typedef struct {
    logic [9:0] td;
    logic       hs;
    logic       vs;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t       q3[$];
  exp_t       q5[$];
  exp_t       m3, m5;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cnt3, cnt5, busy3, busy5;
  int         fval [SZ][RW];
  logic [1:0] src  [SZ][RW];

  function automatic logic [1:0] code_of(input int v);
    if (v == 0) return 2'b00;
    if (v < 0)  return 2'b11;
    return 2'b01;
  endfunction

  // Expected window for output row orow, element a, from the source codes seen so far.
  function automatic exp_t mk(input int orow, input int a, input int len, input int c);
    exp_t e;
    int   half = (len - 1) / 2;
    int   s;
    e.td = '0;
    for (int j = 0; j < len; j++) begin
      s = orow - half + j;
      if (s >= 0 && s < SZ) e.td[2*j +: 2] = src[s][a];
    end
    e.hs   = (a == 0);
    e.vs   = (orow == 0) && (a == 0);
    e.last = (orow == SZ - 1) && (a == RW - 1);
    e.cyc  = c;
    return e;
  endfunction

  // Scoreboard: pop and compare every output as it appears.
  always @(negedge clk) begin
    if (bus3.o_busy) busy3++;
    if (bus5.o_busy) busy5++;
    if (bus3.o_valid) begin
      cnt3++;
      n_tests++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL len3_unexpected_output: got td=%b at cyc %0d, required no output", bus3.o_tdata, cyc);
      end else begin
        m3 = q3.pop_front();
        if (bus3.o_tdata !== m3.td[5:0] || bus3.o_hsync !== m3.hs || bus3.o_vsync !== m3.vs ||
            bus3.o_last !== m3.last || cyc != m3.cyc) begin
          n_fail++;
          $display("FAIL len3_output: got td=%b hs=%b vs=%b last=%b cyc=%0d, required td=%b hs=%b vs=%b last=%b cyc=%0d",
                   bus3.o_tdata, bus3.o_hsync, bus3.o_vsync, bus3.o_last, cyc,
                   m3.td[5:0], m3.hs, m3.vs, m3.last, m3.cyc);
        end
      end
    end
    if (bus5.o_valid) begin
      cnt5++;
      n_tests++;
      if (q5.size() == 0) begin
        n_fail++;
        $display("FAIL len5_unexpected_output: got td=%b at cyc %0d, required no output", bus5.o_tdata, cyc);
      end else begin
        m5 = q5.pop_front();
        if (bus5.o_tdata !== m5.td || bus5.o_hsync !== m5.hs || bus5.o_vsync !== m5.vs ||
            bus5.o_last !== m5.last || cyc != m5.cyc) begin
          n_fail++;
          $display("FAIL len5_output: got td=%b hs=%b vs=%b last=%b cyc=%0d, required td=%b hs=%b vs=%b last=%b cyc=%0d",
                   bus5.o_tdata, bus5.o_hsync, bus5.o_vsync, bus5.o_last, cyc,
                   m5.td, m5.hs, m5.vs, m5.last, m5.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame (optionally with random gaps); stop_at>=0 returns before that element,
  // leaving the previous element still driven.
  task automatic run_frame(input bit gaps, input int stop_at);
    int idx = 0;
    int c = 0;
    cnt3 = 0; cnt5 = 0; busy3 = 0; busy5 = 0;
    for (int r = 0; r < SZ; r++) begin
      for (int a = 0; a < RW; a++) begin
        if (stop_at >= 0 && idx == stop_at) return;
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            step();
            valid = 1'b0;
            vsync = 1'b0;
          end
        end
        step();
        valid = 1'b1;
        vsync = (idx == 0);
        tdata = WD'(fval[r][a]);
        src[r][a] = code_of(fval[r][a]);
        c = cyc;
        if (r >= 1) q3.push_back(mk(r - 1, a, 3, c + 2));
        if (r >= 2) q5.push_back(mk(r - 2, a, 5, c + 2));
        idx++;
      end
    end
    step();
    valid = 1'b0;
    vsync = 1'b0;
    for (int i = 0; i < RW; i++)     q3.push_back(mk(SZ - 1, i, 3, c + 3 + i));
    for (int i = 0; i < 2 * RW; i++) q5.push_back(mk(SZ - 2 + i / RW, i % RW, 5, c + 3 + i));
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((q3.size() != 0 || q5.size() != 0 || bus3.o_busy || bus5.o_busy) && k < 300) begin
      step();
      k++;
    end
    step();
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s_drain: pending q3=%0d q5=%0d after %0d cycles, required 0", nm, q3.size(), q5.size(), k);
    end
  endtask

  task automatic check_counts(input string nm);
    n_tests++;
    if (cnt3 !== 32 || cnt5 !== 32) begin
      n_fail++;
      $display("FAIL %s_count: got len3=%0d len5=%0d, required 32/32", nm, cnt3, cnt5);
    end
    n_tests++;
    if (busy3 !== 8 || busy5 !== 16) begin
      n_fail++;
      $display("FAIL %s_busy: got len3=%0d len5=%0d cycles, required 8/16", nm, busy3, busy5);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < SZ; r++) for (int a = 0; a < RW; a++) fval[r][a] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({bus3.o_valid, bus3.o_vsync, bus3.o_hsync, bus3.o_last, bus3.o_busy, bus3.o_err} !== 6'b0 ||
        bus3.o_tdata !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_len3: got flags=%b td=%b, required 0", {bus3.o_valid, bus3.o_vsync,
               bus3.o_hsync, bus3.o_last, bus3.o_busy, bus3.o_err}, bus3.o_tdata);
    end
    n_tests++;
    if ({bus5.o_valid, bus5.o_vsync, bus5.o_hsync, bus5.o_last, bus5.o_busy, bus5.o_err} !== 6'b0 ||
        bus5.o_tdata !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_len5: got flags=%b td=%b, required 0", {bus5.o_valid, bus5.o_vsync,
               bus5.o_hsync, bus5.o_last, bus5.o_busy, bus5.o_err}, bus5.o_tdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_all_positive();
    fill_const(7);
    run_frame(1'b0, -1);
    wait_drain("all_pos");
    check_counts("all_pos");
  endtask

  task automatic test_sign_codes();
    fill_const(3);
    fval[0][1] = -9;
    fval[1][0] = 0;
    fval[1][1] = -5;
    fval[1][2] = (1 << 26) - 1;
    fval[1][3] = -(1 << 26);
    fval[2][5] = 0;
    fval[3][7] = -1;
    run_frame(1'b0, -1);
    wait_drain("sign_codes");
    check_counts("sign_codes");
  endtask

  task automatic test_gaps();
    fill_const(7);
    run_frame(1'b1, -1);
    wait_drain("gaps_const");
    check_counts("gaps_const");
    for (int r = 0; r < SZ; r++)
      for (int a = 0; a < RW; a++)
        fval[r][a] = (int'($urandom_range(0, 2)) - 1) * int'($urandom_range(1, 1000));
    run_frame(1'b1, -1);
    wait_drain("gaps_random");
    check_counts("gaps_random");
  endtask

  task automatic test_flush_err();
    fill_const(7);
    run_frame(1'b0, -1);
    step();
    step();
    valid = 1'b1;
    tdata = WD'(7);
    step();
    valid = 1'b0;
    wait_drain("flush_err");
    check_counts("flush_err");
    n_tests++;
    if (bus3.o_err !== 1'b1 || bus5.o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_err_set: got len3=%b len5=%b, required 1/1", bus3.o_err, bus5.o_err);
    end
    fill_const(-2);
    run_frame(1'b0, -1);
    wait_drain("err_next_frame");
    check_counts("err_next_frame");
    n_tests++;
    if (bus3.o_err !== 1'b1 || bus5.o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got len3=%b len5=%b, required 1/1", bus3.o_err, bus5.o_err);
    end
  endtask

  task automatic test_reset_midframe();
    fill_const(7);
    run_frame(1'b0, 2 * RW + 2);
    step();
    valid = 1'b0;
    rst   = 1'b1;
    step();
    q3.delete();
    q5.delete();
    n_tests++;
    if (bus3.o_valid !== 1'b0 || bus5.o_valid !== 1'b0 || bus3.o_tdata !== 6'b0 ||
        bus3.o_err !== 1'b0 || bus5.o_err !== 1'b0 || bus3.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got v3=%b v5=%b td3=%b err3=%b err5=%b busy3=%b, required all 0",
               bus3.o_valid, bus5.o_valid, bus3.o_tdata, bus3.o_err, bus5.o_err, bus3.o_busy);
    end
    rst = 1'b0;
    step();
    fill_const(-1);
    run_frame(1'b0, -1);
    wait_drain("after_reset");
    check_counts("after_reset");
  endtask

  task automatic test_back_to_back();
    fill_const(5);
    run_frame(1'b0, 12);
    // Element 11 is still in flight when the new vsync arrives, so its output is squashed.
    void'(q3.pop_back());
    for (int r = 0; r < SZ; r++)
      for (int a = 0; a < RW; a++)
        fval[r][a] = ((r + a) % 3) - 1;
    run_frame(1'b0, -1);
    wait_drain("vsync_abort");
    n_tests++;
    if (cnt5 !== 32) begin
      n_fail++;
      $display("FAIL vsync_abort_len5_count: got %0d, required 32", cnt5);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_positive();
    test_sign_codes();
    test_gaps();
    test_flush_err();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
